// File: rtl/chunked_adder.sv
// -----------------------------------------------------------------------------
// chunked_adder
//
// Multi-cycle adder: Result = DataA + DataB + CarryIn. Each cycle it adds one
// ChunkBits-wide slice of the operands, starting with the least-significant
// slice. The carry between slices is held in a register. This keeps the
// combinational carry chain to ChunkBits+1 bits, so wide accumulations can
// meet timing.
//
// Ports:
//   Clock    - system clock; all state changes on its rising edge
//   Reset    - synchronous, active-high reset (has priority over Start)
//   Start    - request a new addition; only honoured when not Busy
//   CarryIn  - carry into bit 0
//   DataA    - operand A, captured together with Start
//   DataB    - operand B, captured together with Start
//   Busy     - high while slices are being added
//   Done     - one-cycle pulse; Result/CarryOut/Overflow valid from here on
//   CarryOut - carry out of the top bit (unsigned overflow)
//   Overflow - signed two's-complement overflow
//   Result   - sum modulo 2^NrOfBits
// -----------------------------------------------------------------------------
module chunked_adder #(
  parameter int NrOfBits  = 32,
  parameter int ChunkBits = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic                CarryIn,
  input  logic [NrOfBits-1:0] DataA,
  input  logic [NrOfBits-1:0] DataB,
  output logic                Busy,
  output logic                Done,
  output logic                CarryOut,
  output logic                Overflow,
  output logic [NrOfBits-1:0] Result
);

  localparam int NrOfChunks = NrOfBits / ChunkBits;
  // With a single chunk the index is always zero. It still needs one bit so
  // that the register has a legal width.
  localparam int IdxBits = (NrOfChunks > 1) ? $clog2(NrOfChunks) : 1;
  localparam logic [IdxBits-1:0] LastIdx = IdxBits'(NrOfChunks - 1);
  localparam int Msb = NrOfBits - 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [NrOfBits-1:0] opA_q, opA_d;
  logic [NrOfBits-1:0] opB_q, opB_d;
  logic [NrOfBits-1:0] sum_q, sum_d;
  logic [IdxBits-1:0]  idx_q, idx_d;
  logic                carry_q, carry_d;

  logic [NrOfBits-1:0] result_q, result_d;
  logic                carryOut_q, carryOut_d;
  logic                overflow_q, overflow_d;

  logic [ChunkBits-1:0] sliceA, sliceB;
  logic [ChunkBits:0]   sliceSum;

  // Slice adder for the chunk selected by the index. It is one bit wider than
  // a chunk, so its top bit is the carry into the next chunk.
  always_comb begin
    sliceA   = opA_q[idx_q*ChunkBits +: ChunkBits];
    sliceB   = opB_q[idx_q*ChunkBits +: ChunkBits];
    sliceSum = {1'b0, sliceA} + {1'b0, sliceB} + {{ChunkBits{1'b0}}, carry_q};
  end

  // Next-state and datapath control.
  // The visible result registers are loaded only on the step into DONE.
  // Because of that, they never show a partially built sum.
  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    sum_d      = sum_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    result_d   = result_q;
    carryOut_d = carryOut_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          opA_d   = DataA;
          opB_d   = DataB;
          carry_d = CarryIn;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        sum_d[idx_q*ChunkBits +: ChunkBits] = sliceSum[ChunkBits-1:0];
        carry_d = sliceSum[ChunkBits];
        if (idx_q == LastIdx) begin
          state_d    = DONE;
          result_d   = sum_d;
          carryOut_d = sliceSum[ChunkBits];
          // Signed overflow: the operands share a sign bit, but the sum's
          // sign bit differs from it.
          overflow_d = (opA_q[Msb] == opB_q[Msb]) && (sum_d[Msb] != opA_q[Msb]);
        end else begin
          idx_d = idx_q + IdxBits'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      result_q   <= '0;
      carryOut_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      result_q   <= result_d;
      carryOut_q <= carryOut_d;
      overflow_q <= overflow_d;
    end
  end

  assign Busy     = (state_q == RUN);
  assign Done     = (state_q == DONE);
  assign Result   = result_q;
  assign CarryOut = carryOut_q;
  assign Overflow = overflow_q;

endmodule

// File: tb/tb_chunked_adder.sv
// -----------------------------------------------------------------------------
// tb_chunked_adder
//
// Self-checking bench for chunked_adder. It runs two instances:
//   - dut8:  4 chunks of 8 bits.
//   - dut32: a single 32-bit chunk.
// Expected sums, carries and overflows come from a reference model. The model
// uses plain wide arithmetic: unsigned for the carry, and signed 64-bit for
// the signed-overflow check.
// -----------------------------------------------------------------------------
module tb_chunked_adder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        startReq = 1'b0;
  logic        carryIn = 1'b0;
  logic [31:0] dataA = '0;
  logic [31:0] dataB = '0;
  bit          sel = 1'b0;

  logic        start8, busy8, done8, cout8, ovf8;
  logic [31:0] result8;
  logic        start32, busy32, done32, cout32, ovf32;
  logic [31:0] result32;

  logic        busyS, doneS, coutS, ovfS;
  logic [31:0] resultS;

  int assertCount = 0;
  int failCount   = 0;
  logic [31:0] prevRes [2];

  // Only the instance picked by sel sees the start request.
  // The observed outputs are taken from that same instance.
  assign start8  = startReq & ~sel;
  assign start32 = startReq & sel;
  assign busyS   = sel ? busy32   : busy8;
  assign doneS   = sel ? done32   : done8;
  assign coutS   = sel ? cout32   : cout8;
  assign ovfS    = sel ? ovf32    : ovf8;
  assign resultS = sel ? result32 : result8;

  chunked_adder #(.NrOfBits(32), .ChunkBits(8)) dut8 (
    .Clock(clock), .Reset(reset), .Start(start8), .CarryIn(carryIn),
    .DataA(dataA), .DataB(dataB), .Busy(busy8), .Done(done8),
    .CarryOut(cout8), .Overflow(ovf8), .Result(result8)
  );

  chunked_adder #(.NrOfBits(32), .ChunkBits(32)) dut32 (
    .Clock(clock), .Reset(reset), .Start(start32), .CarryIn(carryIn),
    .DataA(dataA), .DataB(dataB), .Busy(busy32), .Done(done32),
    .CarryOut(cout32), .Overflow(ovf32), .Result(result32)
  );

  always #5 clock = ~clock;

  // Single comparison point.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the full-precision sum, from which every output derives.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       output logic [31:0] r, output logic c, output logic v);
    logic [32:0] u;
    longint      s;
    u = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    s = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    r = u[31:0];
    c = u[32];
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endtask

  // Presents the operands with a one-cycle Start.
  // Returns at the first negedge after the accepting edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin);
    dataA    = a;
    dataB    = b;
    carryIn  = cin;
    startReq = 1'b1;
    @(negedge clock);
    startReq = 1'b0;
  endtask

  // Runs one operation. It checks:
  //   - Busy and a stable Result while the operation is running,
  //   - the Done latency and the outputs,
  //   - that Done falls again afterwards.
  // When interfere is set, it pulses Start with new operands mid-run.
  task automatic checkOutput(input logic [31:0] a, input logic [31:0] b, input logic cin,
                             input bit interfere);
    logic [31:0] expR;
    logic        expC, expV;
    int          lat;
    bit          seen;
    model(a, b, cin, expR, expC, expV);
    lat  = sel ? 2 : 5;
    seen = 1'b0;
    applyStimulus(a, b, cin);
    for (int c = 1; c <= lat + 3 && !seen; c++) begin
      if (c > 1) @(negedge clock);
      if (doneS) begin
        seen = 1'b1;
        check("latency", 64'(c), 64'(lat));
        check("result", {32'd0, resultS}, {32'd0, expR});
        check("carryOut", {63'd0, coutS}, {63'd0, expC});
        check("overflow", {63'd0, ovfS}, {63'd0, expV});
      end else begin
        check("busy", {63'd0, busyS}, 64'd1);
        check("resultHold", {32'd0, resultS}, {32'd0, prevRes[sel]});
      end
      if (interfere && c == 2) begin
        startReq = 1'b1;
        dataA    = 32'hFFFF_FFFF;
        dataB    = 32'hFFFF_FFFF;
        carryIn  = 1'b1;
      end
      if (interfere && c == 3) begin
        startReq = 1'b0;
        dataA    = $urandom;
        dataB    = $urandom;
      end
    end
    if (!seen) check("doneTimeout", 64'd0, 64'd1);
    prevRes[sel] = expR;
    @(negedge clock);
    check("doneOnce", {63'd0, doneS}, 64'd0);
    check("idleAfter", {63'd0, busyS}, 64'd0);
    check("resultKept", {32'd0, resultS}, {32'd0, expR});
  endtask

  // Holds Start high for two back-to-back operations: 1+1, then 2+2.
  task automatic backToBack();
    int lat;
    bit expDone;
    lat      = sel ? 2 : 5;
    dataA    = 32'd1;
    dataB    = 32'd1;
    carryIn  = 1'b0;
    startReq = 1'b1;
    for (int c = 1; c <= 2 * lat; c++) begin
      @(negedge clock);
      expDone = (c % lat) == 0;
      check("b2bDone", {63'd0, doneS}, {63'd0, expDone});
      check("b2bBusy", {63'd0, busyS}, {63'd0, !expDone});
      if (c == lat) begin
        check("b2bFirst", {32'd0, resultS}, 64'd2);
        dataA = 32'd2;
        dataB = 32'd2;
      end
      if (c == 2 * lat) begin
        check("b2bSecond", {32'd0, resultS}, 64'd4);
        startReq = 1'b0;
      end
    end
    prevRes[sel] = 32'd4;
    @(negedge clock);
    check("b2bEnd", {63'd0, doneS}, 64'd0);
  endtask

  initial begin
    prevRes[0] = '0;
    prevRes[1] = '0;

    // Reset state.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rstBusy", {63'd0, busy8}, 64'd0);
    check("rstDone", {63'd0, done8}, 64'd0);
    check("rstResult", {32'd0, result8}, 64'd0);
    check("rstCarry", {63'd0, cout8}, 64'd0);
    check("rstOvf", {63'd0, ovf8}, 64'd0);
    check("rstResult32", {32'd0, result32}, 64'd0);

    // Directed cases on the 4-chunk instance.
    sel = 1'b0;
    checkOutput(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    checkOutput(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    checkOutput(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    checkOutput(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    checkOutput(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);

    // Reset on the second RUN cycle aborts the operation.
    applyStimulus(32'hDEAD_BEEF, 32'h0101_0101, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abortBusy", {63'd0, busy8}, 64'd0);
    check("abortResult", {32'd0, result8}, 64'd0);
    check("abortCarry", {63'd0, cout8}, 64'd0);
    check("abortDone", {63'd0, done8}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("abortNoDone", {63'd0, done8}, 64'd0);
    end
    prevRes[0] = '0;
    prevRes[1] = '0;
    checkOutput(32'd5, 32'd7, 1'b0, 1'b0);

    // Back-to-back on both instances.
    backToBack();
    sel = 1'b1;
    backToBack();

    // Randomised operations on both instances.
    sel = 1'b0;
    for (int i = 0; i < 20; i++) checkOutput($urandom, $urandom, 1'($urandom), 1'b0);
    sel = 1'b1;
    checkOutput(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    checkOutput(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) checkOutput($urandom, $urandom, 1'($urandom), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
- Multi-cycle unsigned/two's-complement adder: Result = DataA + DataB + CarryIn, with true carry-in and carry-out polarity.
- Processes ChunkBits per clock, least-significant chunk first, rippling the carry through a register between cycles.
- Sits beside the combinational arithmetic blocks in the arithmetic library. It is the additive counterpart of the borrow-based subtractor, for wide accumulations in the recognition datapath where a full-width combinational carry chain would miss timing.
- Start/Busy/Done handshake toward the controlling FSM.

Parameters:
NrOfBits, 32, operand and result width; must be an integer multiple of ChunkBits
ChunkBits, 8, bits added per cycle
NrOfChunks (derived, not overridable), NrOfBits/ChunkBits, number of add cycles

Ports:
Clock  input  1  system clock; all state changes on its rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request a new addition; sampled only when not Busy
CarryIn  input  1  carry into bit 0 (1 = add one)
DataA  input  NrOfBits  operand A, sampled with Start
DataB  input  NrOfBits  operand B, sampled with Start
Busy  output  1  high while chunks are being added
Done  output  1  one-cycle pulse; Result/CarryOut/Overflow valid from this cycle
CarryOut  output  1  carry out of bit NrOfBits-1 (1 = unsigned overflow)
Overflow  output  1  signed two's-complement overflow
Result  output  NrOfBits  sum modulo 2^NrOfBits

Behaviour:
- Reset is synchronous and active-high: while Reset=1 at a rising edge, state=IDLE and Busy=0, Done=0, CarryOut=0, Overflow=0, Result=0. Internal operand registers, chunk index, carry and partial-sum registers are also cleared. Reset has priority over Start.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with Start=1:
  - Latch DataA, DataB and CarryIn into internal registers; set chunk index=0; go to RUN.
  - Start with Start=0: DONE returns to IDLE, IDLE stays in IDLE.
- RUN, each cycle:
  - Compute slice sum {c, s} = A[k] + B[k] + carry, at ChunkBits+1 bits wide.
  - Write s into slice k of the internal partial-sum register; carry <= c.
  - If k = NrOfChunks-1, go to DONE; otherwise k <= k+1.
- Start while in RUN is ignored and is not queued. Operand input changes during RUN have no effect.
- Transition into DONE: Result <= partial sum, CarryOut <= final carry, and Overflow <= (A[msb]==B[msb]) && (sum[msb]!=A[msb]), using the latched operands.
  - Result, CarryOut and Overflow hold until the next transition into DONE or Reset.
  - They never show partial values.
- Busy=1 exactly in RUN. Done=1 exactly in DONE (one cycle).
- Latency: with Start sampled at edge E0, Done is high in the cycle after edge E0+NrOfChunks. That is NrOfChunks+1 cycles from Start to Done, and throughput is one add per NrOfChunks+1 cycles when back-to-back.
- Back-to-back: Start=1 in the DONE cycle is accepted, so the next RUN begins with no IDLE cycle.
- NrOfChunks=1 (ChunkBits=NrOfBits) is legal: a single RUN cycle, with Done 2 cycles after Start.
- Reset mid-RUN aborts the operation: no Done pulse, outputs cleared, and the next Start behaves normally.

Test Plan:
1. NrOfBits=32, ChunkBits=8; A=0x000000FF, B=0x00000001, CarryIn=0, one-cycle Start -> Busy high for 4 cycles, Done pulses once in the 5th cycle after the Start edge, Result=0x00000100, CarryOut=0, Overflow=0.
2. A=0xFFFFFFFF, B=0x00000000, CarryIn=1 -> carry ripples through all 4 chunks; Result=0x00000000, CarryOut=1, Overflow=0.
3. A=0x7FFFFFFF, B=0x00000001, CarryIn=0 -> Result=0x80000000, CarryOut=0, Overflow=1. Then A=0x80000000, B=0x80000000 -> Result=0, CarryOut=1, Overflow=1.
4. Start A=0x12345678, B=0x11111111. During Busy, pulse Start with A=B=0xFFFFFFFF and change the inputs -> first result is 0x23456789 with a single Done; the second Start is ignored; Result is unchanged in the cycles before Done.
5. Reset for one cycle at the 2nd RUN cycle -> next cycle Busy=0, Result=0, CarryOut=0, no Done. A following Start with 5+7 -> Result=12 after normal latency.
6. Back-to-back: hold Start=1 continuously with 1+1 then 2+2 -> Done pulses every 5 cycles, Result=2 then 4, with no IDLE cycle between operations. Repeat with ChunkBits=32 -> Done every 2 cycles.
